me_best_mv: RTL and testbench

ME_BEST_MV -- requirements
Module: me_best_mv

---
 rtl/me_pkg.sv | 21 ++
 rtl/me_min_tree.sv | 34 +++
 rtl/me_best_mv.sv | 204 ++++++++++++++++++++
 tb/tb_me_best_mv.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared FSM encoding, default sizes and beat-count derivation for the best-MV search
package me_pkg;

    localparam int DEF_BATCH    = 16;
    localparam int DEF_SAD_W    = 14;
    localparam int DEF_SEARCH_W = 32;
    localparam int DEF_SEARCH_H = 32;
    localparam int DEF_MV_W     = 8;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_OUT   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Number of input beats that make up one search block.
    function automatic int nb_calc(input int search_w, input int search_h, input int batch);
        return (search_w * search_h) / batch;
    endfunction

endpackage

// File: rtl/me_min_tree.sv
// rtl/me_min_tree.sv - combinational BATCH-way minimum with lowest-lane tie-break
module me_min_tree #(
    parameter int BATCH = 16,
    parameter int SAD_W = 14,
    parameter int IDX_W = $clog2(BATCH)
) (
    input  logic [BATCH*SAD_W-1:0] sads,
    output logic [SAD_W-1:0]       min_val,
    output logic [IDX_W-1:0]       min_idx
);

    // Heap-ordered reduction tree: leaves hold lanes left to right, each node keeps
    // its left child unless the right child is strictly smaller, so ties go low.
    always_comb begin
        logic [SAD_W-1:0] node_val [2*BATCH-1];
        logic [IDX_W-1:0] node_idx [2*BATCH-1];
        for (int k = 0; k < BATCH; k++) begin
            node_val[BATCH-1+k] = sads[k*SAD_W +: SAD_W];
            node_idx[BATCH-1+k] = IDX_W'(k);
        end
        for (int n = BATCH - 2; n >= 0; n--) begin
            if (node_val[2*n+2] < node_val[2*n+1]) begin
                node_val[n] = node_val[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end else begin
                node_val[n] = node_val[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end
        end
        min_val = node_val[0];
        min_idx = node_idx[0];
    end

endmodule

// File: rtl/me_best_mv.sv
// rtl/me_best_mv.sv - block-wide minimum SAD search with motion vector and early termination
module me_best_mv
    import me_pkg::*;
#(
    parameter int BATCH    = DEF_BATCH,
    parameter int SAD_W    = DEF_SAD_W,
    parameter int SEARCH_W = DEF_SEARCH_W,
    parameter int SEARCH_H = DEF_SEARCH_H,
    parameter int MV_W     = DEF_MV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    et_en,
    input  logic [SAD_W-1:0]        et_thr,
    input  logic                    sad_valid,
    output logic                    sad_ready,
    input  logic [BATCH*SAD_W-1:0]  sad_batch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAD_W-1:0]        best_sad,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic                    early
);

    localparam int COLS = SEARCH_W / BATCH;
    localparam int NB   = nb_calc(SEARCH_W, SEARCH_H, BATCH);
    localparam int LW   = $clog2(BATCH);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

    state_t            state_q;
    state_t            state_d;
    logic              alive_q;
    logic              drain_q;
    logic [BW-1:0]     beat_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic              et_en_q;
    logic [SAD_W-1:0]  et_thr_q;
    logic [SAD_W-1:0]  run_sad;
    logic [MV_W-1:0]   run_mvx;
    logic [MV_W-1:0]   run_mvy;

    logic [SAD_W-1:0]  bmin_val;
    logic [LW-1:0]     bmin_idx;
    logic              accept;
    logic              first;
    logic              last;
    logic              take;
    logic [SAD_W-1:0]  upd_sad;
    logic [MV_W-1:0]   upd_mvx;
    logic [MV_W-1:0]   upd_mvy;
    logic              et_on;
    logic [SAD_W-1:0]  et_lim;
    logic              et_hit;
    logic              load_out;
    logic              set_drain;

    me_min_tree #(
        .BATCH (BATCH),
        .SAD_W (SAD_W),
        .IDX_W (LW)
    ) u_min_tree (
        .sads    (sad_batch),
        .min_val (bmin_val),
        .min_idx (bmin_idx)
    );

    // Running-minimum candidate for this beat; the first beat of a block loads
    // unconditionally and uses the live et inputs since they are latched on it.
    always_comb begin
        accept  = sad_valid && sad_ready;
        first   = (state_q == ST_ACC) && (beat_q == '0);
        last    = (beat_q == BW'(NB - 1));
        take    = first || (bmin_val < run_sad);
        upd_sad = take ? bmin_val : run_sad;
        upd_mvx = take ? MV_W'(int'(col_q) * BATCH + int'(bmin_idx) - SEARCH_W / 2) : run_mvx;
        upd_mvy = take ? MV_W'(int'(row_q) - SEARCH_H / 2) : run_mvy;
        et_on   = first ? et_en : et_en_q;
        et_lim  = first ? et_thr : et_thr_q;
        et_hit  = et_on && (upd_sad < et_lim) && !last;
    end

    // Next-state and handshake decode; a last-beat finish takes priority over early termination.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        set_drain = 1'b0;
        sad_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                sad_ready = alive_q;
                if (accept) begin
                    if (last) begin
                        state_d  = ST_OUT;
                        load_out = 1'b1;
                    end else if (et_hit) begin
                        state_d   = ST_OUT;
                        load_out  = 1'b1;
                        set_drain = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = drain_q ? ST_DRAIN : ST_ACC;
                end
            end
            ST_DRAIN: begin
                sad_ready = alive_q;
                if (accept && last) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State register; alive_q holds sad_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACC;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Raster position counters, advanced on every accepted beat including drained ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (accept) begin
            if (last) begin
                beat_q <= '0;
                col_q  <= '0;
                row_q  <= '0;
            end else begin
                beat_q <= beat_q + BW'(1);
                if (col_q == CW'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Running minimum and the per-block early-termination settings.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sad  <= '0;
            run_mvx  <= '0;
            run_mvy  <= '0;
            et_en_q  <= 1'b0;
            et_thr_q <= '0;
        end else if (accept && (state_q == ST_ACC)) begin
            run_sad <= upd_sad;
            run_mvx <= upd_mvx;
            run_mvy <= upd_mvy;
            if (first) begin
                et_en_q  <= et_en;
                et_thr_q <= et_thr;
            end
        end
    end

    // Result registers, captured on the terminating beat and held through OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad <= '0;
            mv_x     <= '0;
            mv_y     <= '0;
            early    <= 1'b0;
        end else if (load_out) begin
            best_sad <= upd_sad;
            mv_x     <= upd_mvx;
            mv_y     <= upd_mvy;
            early    <= set_drain;
        end
    end

    // Drain flag: set by early termination, cleared once the drained block's last beat passes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_q <= 1'b0;
        end else if (set_drain) begin
            drain_q <= 1'b1;
        end else if ((state_q == ST_DRAIN) && accept && last) begin
            drain_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_me_best_mv.sv
// tb/tb_me_best_mv.sv - directed-table and randomized check of me_best_mv
module tb_me_best_mv;

    localparam int BATCH = 16;
    localparam int SAD_W = 14;
    localparam int SW    = 32;
    localparam int SH    = 4;
    localparam int MV_W  = 8;
    localparam int COLS  = SW / BATCH;
    localparam int NB    = SW * SH / BATCH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   et_en = 1'b0;
    logic [SAD_W-1:0]       et_thr = '0;
    logic                   sad_valid = 1'b0;
    logic                   sad_ready;
    logic [BATCH*SAD_W-1:0] sad_batch = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [SAD_W-1:0]       best_sad;
    logic signed [MV_W-1:0] mv_x;
    logic signed [MV_W-1:0] mv_y;
    logic                   early;

    always #5 clk = ~clk;

    me_best_mv #(
        .BATCH    (BATCH),
        .SAD_W    (SAD_W),
        .SEARCH_W (SW),
        .SEARCH_H (SH),
        .MV_W     (MV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .et_en     (et_en),
        .et_thr    (et_thr),
        .sad_valid (sad_valid),
        .sad_ready (sad_ready),
        .sad_batch (sad_batch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .best_sad  (best_sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .early     (early)
    );

    typedef struct {
        logic              een;
        logic [SAD_W-1:0]  thr;
        logic [SAD_W-1:0]  base;
        int                b1;
        int                l1;
        logic [SAD_W-1:0]  v1;
        int                b2;
        int                l2;
        logic [SAD_W-1:0]  v2;
        logic [SAD_W-1:0]  e_sad;
        logic signed [7:0] e_mvx;
        logic signed [7:0] e_mvy;
        logic              e_early;
        int                e_term;
        int                stall;
    } vec_t;

    vec_t             tbl [10];
    logic [SAD_W-1:0] blk [NB][BATCH];
    int               n_checks = 0;
    int               n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill_from(input vec_t v);
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < BATCH; l++)
                blk[b][l] = v.base;
        blk[v.b1][v.l1] = v.v1;
        blk[v.b2][v.l2] = v.v2;
    endtask

    task automatic pack_beat(input int b);
        for (int l = 0; l < BATCH; l++)
            sad_batch[l*SAD_W +: SAD_W] = blk[b][l];
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (sad_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(sad_ready), 32'd1);
    endtask

    task automatic check_result(input logic [SAD_W-1:0] e_sad, input logic signed [7:0] e_mvx,
                                input logic signed [7:0] e_mvy, input logic e_early);
        chk("best_sad", 32'(best_sad), 32'(e_sad));
        chk("mv_x", 32'(mv_x), 32'(e_mvx));
        chk("mv_y", 32'(mv_y), 32'(e_mvy));
        chk("early", 32'(early), 32'(e_early));
    endtask

    // Independent raster-order reference: strict-less update, early stop before the last beat.
    task automatic model_block(input logic een, input logic [SAD_W-1:0] thr,
                               output logic [SAD_W-1:0] e_sad, output logic signed [7:0] e_mvx,
                               output logic signed [7:0] e_mvy, output logic e_early, output int e_term);
        logic [SAD_W-1:0] m;
        int pb, pl;
        m = blk[0][0]; pb = 0; pl = 0;
        e_term = NB - 1; e_early = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < BATCH; l++) begin
                if (blk[b][l] < m) begin
                    m = blk[b][l]; pb = b; pl = l;
                end
            end
            if (een && m < thr && b < NB - 1) begin
                e_term = b; e_early = 1'b1;
                break;
            end
        end
        e_sad = m;
        e_mvx = 8'((pb % COLS) * BATCH + pl - SW / 2);
        e_mvy = 8'(pb / COLS - SH / 2);
    endtask

    task automatic run_block(input logic een, input logic [SAD_W-1:0] thr, input logic [SAD_W-1:0] e_sad,
                             input logic signed [7:0] e_mvx, input logic signed [7:0] e_mvy,
                             input logic e_early, input int e_term, input int stall, input bit gaps);
        et_en = een;
        et_thr = thr;
        for (int b = 0; b < NB; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sad_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            pack_beat(b);
            sad_valid = 1'b1;
            wait_ready();
            @(negedge clk);
            sad_valid = 1'b0;
            if (gaps && b == 0) begin
                et_en = 1'($urandom);
                et_thr = 14'($urandom);
            end
            if (b == e_term) begin
                chk("latency_out_valid", 32'(out_valid), 32'd1);
                if (b + 1 < NB) begin
                    pack_beat(b + 1);
                    sad_valid = 1'b1;
                end
                for (int c = 0; c < stall; c++) begin
                    chk("stall_sad_ready", 32'(sad_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    check_result(e_sad, e_mvx, e_mvy, e_early);
                    @(negedge clk);
                end
                check_result(e_sad, e_mvx, e_mvy, e_early);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk("out_valid_drop", 32'(out_valid), 32'd0);
            end else begin
                chk("out_valid_quiet", 32'(out_valid), 32'd0);
            end
        end
        sad_valid = 1'b0;
    endtask

    initial begin
        logic [SAD_W-1:0]  r_sad;
        logic signed [7:0] r_mvx, r_mvy;
        logic              r_early, r_een;
        logic [SAD_W-1:0]  r_thr;
        int                r_term;
        int                mode;

        tbl[0] = '{1'b0, 14'd0,     14'd100,   5, 3,  14'd7,     5, 3,  14'd7,     14'd7,     8'sd3,   8'sd0,  1'b0, 7, 10};
        tbl[1] = '{1'b0, 14'd0,     14'd100,   0, 10, 14'd9,     6, 0,  14'd9,     14'd9,     -8'sd6,  -8'sd2, 1'b0, 7, 0};
        tbl[2] = '{1'b1, 14'd20,    14'd100,   2, 5,  14'd15,    2, 5,  14'd15,    14'd15,    -8'sd11, -8'sd1, 1'b1, 2, 3};
        tbl[3] = '{1'b0, 14'd0,     14'd50,    7, 15, 14'd3,     7, 15, 14'd3,     14'd3,     8'sd15,  8'sd1,  1'b0, 7, 0};
        tbl[4] = '{1'b1, 14'd20,    14'd100,   7, 0,  14'd15,    7, 0,  14'd15,    14'd15,    8'sd0,   8'sd1,  1'b0, 7, 0};
        tbl[5] = '{1'b1, 14'd5,     14'd100,   3, 8,  14'd5,     3, 8,  14'd5,     14'd5,     8'sd8,   -8'sd1, 1'b0, 7, 0};
        tbl[6] = '{1'b1, 14'd20,    14'd100,   0, 15, 14'd0,     2, 0,  14'd100,   14'd0,     -8'sd1,  -8'sd2, 1'b1, 0, 2};
        tbl[7] = '{1'b0, 14'd0,     14'd200,   4, 7,  14'd11,    4, 2,  14'd11,    14'd11,    -8'sd14, 8'sd0,  1'b0, 7, 0};
        tbl[8] = '{1'b0, 14'd0,     14'd16383, 0, 0,  14'd16383, 0, 0,  14'd16383, 14'd16383, -8'sd16, -8'sd2, 1'b0, 7, 0};
        tbl[9] = '{1'b1, 14'd50,    14'd60,    3, 1,  14'd49,    3, 1,  14'd49,    14'd49,    8'sd1,   -8'sd1, 1'b1, 3, 1};

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sad_ready", 32'(sad_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_result(14'd0, 8'sd0, 8'sd0, 1'b0);
        rst = 1'b1;
        chk("rel_sad_ready_low", 32'(sad_ready), 32'd0);
        @(negedge clk);
        chk("rel_sad_ready_high", 32'(sad_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            fill_from(tbl[i]);
            run_block(tbl[i].een, tbl[i].thr, tbl[i].e_sad, tbl[i].e_mvx, tbl[i].e_mvy,
                      tbl[i].e_early, tbl[i].e_term, tbl[i].stall, 1'b0);
        end

        // Reset in the middle of a block, then a fresh block must come out right.
        fill_from(tbl[0]);
        et_en = 1'b0;
        for (int b = 0; b < 5; b++) begin
            pack_beat(b);
            sad_valid = 1'b1;
            wait_ready();
            @(negedge clk);
        end
        sad_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_sad_ready", 32'(sad_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        check_result(14'd0, 8'sd0, 8'sd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_rel_low", 32'(sad_ready), 32'd0);
        @(negedge clk);
        chk("midrst_rel_high", 32'(sad_ready), 32'd1);
        run_block(tbl[0].een, tbl[0].thr, tbl[0].e_sad, tbl[0].e_mvx, tbl[0].e_mvy,
                  tbl[0].e_early, tbl[0].e_term, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            mode = $urandom_range(0, 1);
            for (int b = 0; b < NB; b++)
                for (int l = 0; l < BATCH; l++)
                    blk[b][l] = (mode == 1) ? 14'($urandom_range(0, 15)) :
                                (($urandom_range(0, 63) == 0) ? 14'($urandom_range(0, 40)) :
                                                                14'($urandom_range(30, 16383)));
            r_een = 1'($urandom_range(0, 1));
            r_thr = 14'($urandom_range(0, 40));
            model_block(r_een, r_thr, r_sad, r_mvx, r_mvy, r_early, r_term);
            run_block(r_een, r_thr, r_sad, r_mvx, r_mvy, r_early, r_term, $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
